// File: rtl/affine3_op2.sv
// affine3_op2 -- second stage of the affine3 datapath.
// Accumulates NUM_PART partial sums from the first-stage weighted adder,
// adding the ones-complement correction (ninv_in) to each, plus a bias
// taken on the first beat. The sum is then arithmetic-shifted by SHIFT,
// saturated to 6-bit signed and offered downstream over valid/ready.
// Optional build macro: AFFINE3_RELU_EN clamps negative shifted sums to 0
// before saturation, giving data_out in 0..31.
module affine3_op2 #(
  parameter int NUM_PART = 4,
  parameter int SHIFT    = 2,
  parameter int ACC_W    = 14
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] part_in,
  input  logic [4:0] ninv_in,
  input  logic [9:0] bias_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] data_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Count value held while waiting for the final beat of a group.
  localparam logic [4:0] LAST_CNT = 5'(NUM_PART - 1);

  // Saturation bounds of the 6-bit signed result, at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(31);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [4:0]       cnt_q;
  logic             out_valid_q;
  logic [5:0]       data_out_q;

  logic             beat_acc;
  logic             last_beat;
  logic [ACC_W-1:0] bias_ext;
  logic [ACC_W-1:0] part_ext;
  logic [ACC_W-1:0] ninv_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic signed [ACC_W-1:0] clip_s;
  logic [5:0]       sat_d;

  // Handshake status: ready only while collecting beats and out of reset.
  always_comb begin
    in_ready  = (state_q != ST_OUT) && !reset;
    beat_acc  = in_valid && in_ready;
    busy      = (state_q != ST_IDLE);
    out_valid = out_valid_q;
    data_out  = data_out_q;
  end

  // Next accumulator value: bias seeds the sum on the first beat, then each
  // beat adds its partial sum plus the inverted-input count so that every
  // inverted input contributes exactly -x.
  always_comb begin
    bias_ext  = {{(ACC_W-10){bias_in[9]}}, bias_in};
    part_ext  = {{(ACC_W-10){part_in[9]}}, part_in};
    ninv_ext  = {{(ACC_W-5){1'b0}}, ninv_in};
    acc_base  = (state_q == ST_IDLE) ? bias_ext : acc_q;
    acc_d     = acc_base + part_ext + ninv_ext;
    last_beat = (state_q == ST_IDLE) ? (NUM_PART == 1) : (cnt_q == LAST_CNT);
  end

  // Final scaling of the completed sum: floor shift, optional ReLU, 6-bit clamp.
  always_comb begin
    acc_s     = $signed(acc_d);
    shifted_s = acc_s >>> SHIFT;
`ifdef AFFINE3_RELU_EN
    clip_s    = shifted_s[ACC_W-1] ? '0 : shifted_s;
`else
    clip_s    = shifted_s;
`endif
    if (clip_s > SAT_MAX) begin
      sat_d = 6'b011111;
    end else if (clip_s < SAT_MIN) begin
      sat_d = 6'b100000;
    end else begin
      sat_d = clip_s[5:0];
    end
  end

  // Control FSM with registered outputs; result is captured on the last beat
  // so out_valid rises exactly one cycle after that beat is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (beat_acc) begin
            acc_q <= acc_d;
            cnt_q <= 5'd1;
            if (last_beat) begin
              state_q     <= ST_OUT;
              out_valid_q <= 1'b1;
              data_out_q  <= sat_d;
            end else begin
              state_q <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (beat_acc) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (last_beat) begin
              state_q     <= ST_OUT;
              out_valid_q <= 1'b1;
              data_out_q  <= sat_d;
            end
          end
        end
        ST_OUT: begin
          // data_out intentionally keeps its value after the handshake.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_affine3_op2.sv
// Testbench for affine3_op2 (NUM_PART=4, SHIFT=2). A transaction-level model
// tracks beats and the pending result; a compare process checks every cycle.
module tb_affine3_op2;

  localparam int NP = 4;
  localparam int SH = 2;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] part_in;
  logic [4:0] ninv_in;
  logic [9:0] bias_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] data_out;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  affine3_op2 #(.NUM_PART(NP), .SHIFT(SH), .ACC_W(14)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .part_in(part_in), .ninv_in(ninv_in), .bias_in(bias_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected 6-bit result from an exact integer sum.
  function automatic int scale(input int sum);
    int v;
    v = sum >>> SH;            // floor division by 2**SH on a 32-bit int
`ifdef AFFINE3_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 31) v = 31;
    if (v < -32) v = -32;
    return v;
  endfunction

  // Transaction-level model state.
  int m_beats = 0;
  int m_sum = 0;
  bit m_valid = 0;
  int m_data = 0;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_beats = 0; m_sum = 0; m_valid = 0; m_data = 0;
      end else if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (in_valid) begin
        if (m_beats == 0) m_sum = $signed(bias_in);
        m_sum += $signed(part_in) + int'(ninv_in);
        m_beats++;
        if (m_beats == NP) begin
          m_data = scale(m_sum);
          m_valid = 1;
          m_beats = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("data_out", int'($signed(data_out)), m_data);
      chk("in_ready", int'(in_ready), int'(!reset && !m_valid));
      chk("busy", int'(busy), int'(m_valid || m_beats != 0));
    end
  end

  // One beat; inputs change 1 time unit after the edge.
  task automatic beat(input int bias, input int part, input int ninv);
    in_valid = 1'b1;
    bias_in  = 10'(bias);
    part_in  = 10'(part);
    ninv_in  = 5'(ninv);
    @(posedge clock); #1;
    in_valid = 1'b0;
    bias_in  = 10'h155;          // garbage: must be ignored outside first beat
  endtask

  // Wait (bounded) for out_valid, hold back-pressure, handshake, report.
  task automatic finish_txn(input string name, input int exp, input int stall);
    int n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clock); #1; n++;
    end
    chk({name, "_latency"}, n, 0);
    repeat (stall) begin @(posedge clock); #1; end
    chk({name, "_value"}, int'($signed(data_out)), exp);
    $display("[TB] txn %s data_out=%0d out_valid=%0b", name, $signed(data_out), out_valid);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({name, "_drop"}, int'(out_valid), 0);
  endtask

  task automatic seq4(input int bias, input int p0, input int p1, input int p2,
                      input int p3, input int n0, input int n1, input int n2,
                      input int n3, input int gap);
    beat(bias, p0, n0);
    repeat (gap) begin @(posedge clock); #1; end
    beat(bias, p1, n1);
    repeat (gap) begin @(posedge clock); #1; end
    beat(bias, p2, n2);
    repeat (gap) begin @(posedge clock); #1; end
    beat(bias, p3, n3);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; out_ready = 0;
    part_in = 0; ninv_in = 0; bias_in = 0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    seq4(0, 10, 20, 30, 40, 0, 0, 0, 0, 0);
    finish_txn("basic", 25, 0);

    seq4(0, -1, -1, -1, -1, 1, 1, 1, 1, 0);
    finish_txn("ninv_corr", 0, 0);

    seq4(0, 511, 511, 511, 511, 0, 0, 0, 0, 0);
    finish_txn("sat_pos", 31, 0);

`ifdef AFFINE3_RELU_EN
    seq4(0, -512, -512, -512, -512, 0, 0, 0, 0, 0);
    finish_txn("sat_neg", 0, 0);
    seq4(-5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    finish_txn("floor", 0, 0);
`else
    seq4(0, -512, -512, -512, -512, 0, 0, 0, 0, 0);
    finish_txn("sat_neg", -32, 0);
    seq4(-5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    finish_txn("floor", -2, 0);
`endif

    // Mixed ninv, gapped input, back-pressure with in_valid held high in OUT.
    // 100 + 5 + (-40+4) + (0+16) + (-1+1) = 85 -> 85>>>2 = 21
    seq4(100, 5, -40, 0, -1, 0, 4, 16, 1, 2);
    in_valid = 1'b1; part_in = 10'd300; ninv_in = 5'd7;
    finish_txn("backpressure", 21, 5);

    // Reset in the middle of a group, then a fresh clean group.
    beat(0, 200, 3);
    beat(0, 200, 3);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    seq4(0, 10, 20, 30, 40, 0, 0, 0, 0, 0);
    finish_txn("after_rst", 25, 0);

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/affine3_op2.md
Name: affine3_op2

Overview:
- Second stage of the affine3 datapath; sits directly downstream of the first-stage 16-input weighted adder.
- Accumulates NUM_PART consecutive 10-bit partial sums from that adder into one neuron sum.
- For each partial sum, adds the ones-complement correction (count of inverted inputs) so every inverted input contributes exactly -x, not -x-1.
- Adds a bias, arithmetic-shifts, saturates to 6-bit signed, and hands the result to the next layer over a valid/ready handshake.

Parameters:
- NUM_PART, 4, number of partial sums per output (1..16).
- SHIFT, 2, arithmetic right-shift applied to the final sum (0..7).
- ACC_W, 14, accumulator width in bits; must hold |bias| + NUM_PART*(512+16).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  partial-sum beat valid.
- in_ready  output  1  block can accept a beat.
- part_in  input  10  first-stage sum, two's complement.
- ninv_in  input  5  number of inverted inputs in this partial sum (0..16).
- bias_in  input  10  signed bias; sampled on the first beat only.
- out_valid  output  1  data_out valid.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  6  saturated signed result.
- busy  output  1  high in ACC or OUT.

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, cnt=0, out_valid=0, data_out=0, busy=0. in_ready=0 while reset is high.
- in_ready=1 in IDLE and ACC, 0 in OUT (combinational from state). A beat is accepted when in_valid && in_ready.
- IDLE, beat accepted:
  - acc <= sext(bias_in) + sext(part_in) + zext(ninv_in); cnt <= 1.
  - Next state is OUT if NUM_PART==1, otherwise ACC.
- ACC, beat accepted:
  - acc <= acc + sext(part_in) + zext(ninv_in); cnt <= cnt+1.
  - On the NUM_PART-th beat, go to OUT. bias_in is ignored in ACC.
- ACC, no beat: hold acc and cnt. There is no timeout.
- Transition into OUT (registered):
  - data_out <= sat6(acc >>> SHIFT); out_valid <= 1.
  - sat6 range is -32..31. The shift is arithmetic, i.e. floor toward -inf.
  - out_valid rises the cycle after the last beat is accepted (latency 1).
- OUT:
  - data_out and out_valid are held stable until out_ready=1.
  - On handshake: next cycle out_valid=0, state=IDLE, cnt=0. data_out keeps its last value.
  - No new beat is accepted in the handshake cycle. Minimum period is NUM_PART+1 cycles per output.
- Arithmetic:
  - All additions are ACC_W bits, two's complement.
  - Overflow past ACC_W wraps. This is not detected and is excluded by parameter choice.
  - ninv_in > 16 is not checked; it is added as given.

Optional Feature:
- AFFINE3_RELU_EN defined: after the shift, a negative value is forced to 0 before saturation, so data_out is in 0..31.
- Undefined: full signed saturation to -32..31.
- Handshake and timing are identical either way.

Test Plan (NUM_PART=4, SHIFT=2):
- Basic sum: bias 0; parts 10,20,30,40; ninv 0 -> acc 100 -> data_out=25, out_valid rises 1 cycle after beat 4.
- Inversion correction: bias 0; four parts of -1, each ninv=1 -> acc 0 -> data_out=0.
- Saturation, positive: four parts of 511, ninv 0 -> 2044>>>2=511 -> data_out=31.
- Saturation, negative: four parts of -512 -> -512 -> data_out=-32 (0 with AFFINE3_RELU_EN).
- Floor rounding: bias -5; parts 0,0,0,0 -> -5>>>2 -> data_out=-2 (0 with RELU).
- Back-pressure, gapped input, and reset:
  - Hold out_ready=0 for 5 cycles -> out_valid=1, data_out constant, in_ready=0 throughout; in_valid gaps during ACC just stall.
  - Then out_ready=1 -> out_valid=0 next cycle.
  - Assert reset after 2 beats -> all outputs 0 immediately; a fresh 4-beat sequence then gives its exact result with no residue.
